// File: rtl/register_file_param_if.sv
// Register-file bus: decode read/write addressing in, registered operands and debug bank out.
interface register_file_param_if #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 15
);
  logic                       re;
  logic [ADDR_W-1:0]          a1;
  logic [ADDR_W-1:0]          a2;
  logic                       we_rf;
  logic [ADDR_W-1:0]          rd;
  logic [DATA_W-1:0]          wd3;
  logic [DATA_W-1:0]          pc_in;
  logic [DATA_W-1:0]          rd1;
  logic [DATA_W-1:0]          rd2;
  logic                       rd_valid;
  logic [NUM_REGS*DATA_W-1:0] register_bank;

  modport master (
    output re, a1, a2, we_rf, rd, wd3, pc_in,
    input  rd1, rd2, rd_valid, register_bank
  );

  modport slave (
    input  re, a1, a2, we_rf, rd, wd3, pc_in,
    output rd1, rd2, rd_valid, register_bank
  );
endinterface

// File: rtl/register_file_param.sv
// Two-read/one-write register file with registered write-first reads and a PC alias at the top address.
module register_file_param #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 4,
  parameter int NUM_REGS  = 15,
  parameter int PC_OFFSET = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  register_file_param_if.slave bus
);

  localparam logic [ADDR_W-1:0] PC_ADDR = '1;
  localparam logic [ADDR_W-1:0] NREGS_A = ADDR_W'(NUM_REGS);

  logic [DATA_W-1:0]          r_regs [NUM_REGS];
  logic [DATA_W-1:0]          r_rd1_p1;
  logic [DATA_W-1:0]          r_rd2_p1;
  logic                       r_vld_p1;
  logic                       w_wr_hit;
  logic [NUM_REGS*DATA_W-1:0] w_bank;
  logic [DATA_W-1:0]          w_pc_val;
  logic [DATA_W-1:0]          w_rd1_p0;
  logic [DATA_W-1:0]          w_rd2_p0;

  function automatic logic [DATA_W-1:0] pc_plus_offset(input logic [DATA_W-1:0] pc);
    return pc + DATA_W'(PC_OFFSET);
  endfunction

  // Write-first: a same-edge write to the read address wins over stored contents.
  function automatic logic [DATA_W-1:0] read_value(
    input logic [ADDR_W-1:0]          addr,
    input logic [NUM_REGS*DATA_W-1:0] bank,
    input logic                       wr_hit,
    input logic [ADDR_W-1:0]          wr_addr,
    input logic [DATA_W-1:0]          wr_data,
    input logic [DATA_W-1:0]          pc_val
  );
    logic [DATA_W-1:0] v;
    v = '0;
    if (wr_hit && (addr == wr_addr))
      v = wr_data;
    else if (addr < NREGS_A)
      v = bank[addr*DATA_W +: DATA_W];
    else if (addr == PC_ADDR)
      v = pc_val;
    return v;
  endfunction

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_bank
    assign w_bank[g*DATA_W +: DATA_W] = r_regs[g];
  end

  assign w_wr_hit = bus.we_rf && (bus.rd < NREGS_A);
  assign w_pc_val = pc_plus_offset(bus.pc_in);

  // Stage p0: address decode and bypass selection
  always_comb begin
    w_rd1_p0 = read_value(bus.a1, w_bank, w_wr_hit, bus.rd, bus.wd3, w_pc_val);
    w_rd2_p0 = read_value(bus.a2, w_bank, w_wr_hit, bus.rd, bus.wd3, w_pc_val);
  end

  // Stage p1: register array update and read-data registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        r_regs[i] <= '0;
      r_rd1_p1 <= '0;
      r_rd2_p1 <= '0;
      r_vld_p1 <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++)
        if (w_wr_hit && (bus.rd == ADDR_W'(i)))
          r_regs[i] <= bus.wd3;
      if (bus.re) begin
        r_rd1_p1 <= w_rd1_p0;
        r_rd2_p1 <= w_rd2_p0;
      end
      r_vld_p1 <= bus.re;
    end
  end

  assign bus.rd1           = r_rd1_p1;
  assign bus.rd2           = r_rd2_p1;
  assign bus.rd_valid      = r_vld_p1;
  assign bus.register_bank = w_bank;

endmodule

// File: tb/tb_register_file_param.sv
// Directed table, small-file corner sequence and random regression for register_file_param.
module tb_register_file_param;

  localparam int NR = 15;

  typedef struct {
    logic        rst;
    logic        re;
    logic [3:0]  a1;
    logic [3:0]  a2;
    logic        we;
    logic [3:0]  rd;
    logic [31:0] wd;
    logic [31:0] pc;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        ev;
    int          ri;
    logic [31:0] er;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [31:0] m_regs [NR];
  logic [31:0] m_rd1, m_rd2;
  logic        m_vld;

  vec_t tbl [15];

  always #5 clk = ~clk;

  register_file_param_if #(.DATA_W(32), .ADDR_W(4), .NUM_REGS(15)) bus ();
  register_file_param_if #(.DATA_W(32), .ADDR_W(4), .NUM_REGS(8))  bus8 ();

  register_file_param #(.DATA_W(32), .ADDR_W(4), .NUM_REGS(15), .PC_OFFSET(8)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  register_file_param #(.DATA_W(32), .ADDR_W(4), .NUM_REGS(8), .PC_OFFSET(8)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  function automatic vec_t mk(input logic r, input logic re, input logic [3:0] a1, input logic [3:0] a2,
                              input logic we, input logic [3:0] rd, input logic [31:0] wd,
                              input logic [31:0] pc, input logic [31:0] e1, input logic [31:0] e2,
                              input logic ev, input int ri, input logic [31:0] er);
    vec_t v;
    v.rst = r; v.re = re; v.a1 = a1; v.a2 = a2; v.we = we; v.rd = rd; v.wd = wd; v.pc = pc;
    v.e1 = e1; v.e2 = e2; v.ev = ev; v.ri = ri; v.er = er;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_bank(input string nm, input logic [NR*32-1:0] act, input logic [NR*32-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [3:0] addr);
    if (bus.we_rf && bus.rd < 4'd15 && bus.rd == addr) return bus.wd3;
    if (addr < 4'd15) return m_regs[addr];
    return bus.pc_in + 32'd8;
  endfunction

  // Advances the reference model by one edge using the inputs currently driven.
  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < NR; i++) m_regs[i] = '0;
      m_rd1 = '0; m_rd2 = '0; m_vld = 1'b0;
    end else begin
      if (bus.re) begin
        m_rd1 = m_read(bus.a1);
        m_rd2 = m_read(bus.a2);
      end
      m_vld = bus.re;
      if (bus.we_rf && bus.rd < 4'd15) m_regs[bus.rd] = bus.wd3;
    end
  endtask

  function automatic logic [NR*32-1:0] m_bank();
    logic [NR*32-1:0] b;
    for (int i = 0; i < NR; i++) b[i*32 +: 32] = m_regs[i];
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [NR*32-1:0] exp8;
    rst = 1'b1;
    bus.re = 0;  bus.a1 = 0;  bus.a2 = 0;  bus.we_rf = 0;  bus.rd = 0;  bus.wd3 = 0;  bus.pc_in = 0;
    bus8.re = 0; bus8.a1 = 0; bus8.a2 = 0; bus8.we_rf = 0; bus8.rd = 0; bus8.wd3 = 0; bus8.pc_in = 0;

    //              rst re a1 a2 we rd wd            pc            e1            e2            ev ri er
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 32'h0);
    tbl[1]  = mk(0, 0, 0, 0, 1, 3, 32'hDEADBEEF, 32'h0,        32'h0,        32'h0,        0, 3, 32'hDEADBEEF);
    tbl[2]  = mk(1, 1, 3, 3, 1, 3, 32'h1,        32'h0,        32'h0,        32'h0,        0, 3, 32'h0);
    tbl[3]  = mk(0, 0, 0, 0, 1, 5, 32'h12345678, 32'h0,        32'h0,        32'h0,        0, 5, 32'h12345678);
    tbl[4]  = mk(0, 1, 5, 0, 0, 0, 32'h0,        32'h0,        32'h12345678, 32'h0,        1, 5, 32'h12345678);
    tbl[5]  = mk(0, 0, 0, 0, 1, 7, 32'hAAAA,     32'h0,        32'h12345678, 32'h0,        0, 7, 32'hAAAA);
    tbl[6]  = mk(0, 1, 7, 7, 1, 7, 32'h5555,     32'h0,        32'h5555,     32'h5555,     1, 7, 32'h5555);
    tbl[7]  = mk(0, 1, 15, 3, 0, 0, 32'h0,       32'h100,      32'h108,      32'h0,        1, 7, 32'h5555);
    tbl[8]  = mk(0, 1, 15, 15, 0, 0, 32'h0,      32'hFFFFFFFC, 32'h4,        32'h4,        1, 3, 32'h0);
    tbl[9]  = mk(0, 0, 1, 2, 1, 15, 32'h77,      32'h200,      32'h4,        32'h4,        0, 7, 32'h5555);
    tbl[10] = mk(0, 1, 2, 7, 1, 2, 32'h11,       32'h0,        32'h11,       32'h5555,     1, 2, 32'h11);
    tbl[11] = mk(0, 0, 0, 0, 1, 2, 32'h22,       32'h0,        32'h11,       32'h5555,     0, 2, 32'h22);
    tbl[12] = mk(0, 1, 2, 14, 1, 14, 32'hCAFE,   32'h0,        32'h22,       32'hCAFE,     1, 14, 32'hCAFE);
    tbl[13] = mk(0, 1, 0, 15, 0, 0, 32'h0,       32'h0,        32'h0,        32'h8,        1, 14, 32'hCAFE);
    tbl[14] = mk(1, 1, 2, 2, 1, 4, 32'h9,        32'h0,        32'h0,        32'h0,        0, 14, 32'h0);

    for (int i = 0; i < 15; i++) begin
      rst = tbl[i].rst;       bus.re = tbl[i].re; bus.a1 = tbl[i].a1; bus.a2 = tbl[i].a2;
      bus.we_rf = tbl[i].we;  bus.rd = tbl[i].rd; bus.wd3 = tbl[i].wd; bus.pc_in = tbl[i].pc;
      model_edge();
      tick();
      chk($sformatf("row%0d rd1", i), bus.rd1, tbl[i].e1);
      chk($sformatf("row%0d rd2", i), bus.rd2, tbl[i].e2);
      chk($sformatf("row%0d rd_valid", i), {31'b0, bus.rd_valid}, {31'b0, tbl[i].ev});
      chk($sformatf("row%0d R%0d", i, tbl[i].ri), bus.register_bank[tbl[i].ri*32 +: 32], tbl[i].er);
      chk_bank($sformatf("row%0d bank", i), bus.register_bank, m_bank());
    end

    // Eight-register file: unmapped reads, ignored unmapped writes, hold with re=0.
    rst = 1'b0;
    bus.re = 0; bus.we_rf = 0;
    bus8.we_rf = 1; bus8.rd = 1; bus8.wd3 = 32'hABCD;
    tick();
    chk("n8 R1 write", bus8.register_bank[32 +: 32], 32'hABCD);

    bus8.we_rf = 1; bus8.rd = 9; bus8.wd3 = 32'hFF; bus8.re = 1; bus8.a1 = 10; bus8.a2 = 1;
    tick();
    exp8 = '0;
    exp8[32 +: 32] = 32'hABCD;
    chk("n8 unmapped rd1", bus8.rd1, 32'h0);
    chk("n8 rd2", bus8.rd2, 32'hABCD);
    chk("n8 rd_valid", {31'b0, bus8.rd_valid}, 32'h1);
    chk_bank("n8 bank after unmapped write", {{(NR-8)*32{1'b0}}, bus8.register_bank}, exp8);

    bus8.we_rf = 1; bus8.rd = 1; bus8.wd3 = 32'h99; bus8.re = 0; bus8.a1 = 1; bus8.a2 = 3;
    tick();
    chk("n8 hold rd1", bus8.rd1, 32'h0);
    chk("n8 hold rd2", bus8.rd2, 32'hABCD);
    chk("n8 hold rd_valid", {31'b0, bus8.rd_valid}, 32'h0);
    chk("n8 R1 rewrite", bus8.register_bank[32 +: 32], 32'h99);

    bus8.we_rf = 0; bus8.re = 1; bus8.a1 = 8; bus8.a2 = 15; bus8.pc_in = 32'h20;
    tick();
    bus8.pc_in = 32'h500;
    chk("n8 addr8 unmapped", bus8.rd1, 32'h0);
    chk("n8 pc read", bus8.rd2, 32'h28);

    bus8.re = 1; bus8.a1 = 7; bus8.a2 = 1;
    tick();
    chk("n8 R7", bus8.rd1, 32'h0);
    chk("n8 R1 read", bus8.rd2, 32'h99);
    bus8.re = 0;

    // Random regression against the reference model, bypass-biased.
    for (int c = 0; c < 3000; c++) begin
      rst = (c == 0) || ($urandom_range(0, 63) == 0);
      bus.re    = $urandom_range(0, 1);
      bus.a1    = 4'($urandom_range(0, 15));
      bus.a2    = ($urandom_range(0, 3) == 0) ? bus.a1 : 4'($urandom_range(0, 15));
      bus.we_rf = $urandom_range(0, 1);
      bus.rd    = ($urandom_range(0, 1) == 0) ? bus.a1 : 4'($urandom_range(0, 15));
      bus.wd3   = $urandom;
      bus.pc_in = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF8 + 32'($urandom_range(0, 7))) : $urandom;
      model_edge();
      tick();
      chk($sformatf("rand%0d rd1", c), bus.rd1, m_rd1);
      chk($sformatf("rand%0d rd2", c), bus.rd2, m_rd2);
      chk($sformatf("rand%0d rd_valid", c), {31'b0, bus.rd_valid}, {31'b0, m_vld});
      chk_bank($sformatf("rand%0d bank", c), bus.register_bank, m_bank());
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
